// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants for the VGA test-pattern generator: mode encodings and
// default 640x480 timing landmarks.
package vga_pattern_gen_pkg;

    typedef enum logic [2:0] {
        ModeBlack   = 3'd0,
        ModeHStripe = 3'd1,
        ModeVStripe = 3'd2,
        ModeChecker = 3'd3,
        ModeBars    = 3'd4,
        ModeRamp    = 3'd5
    } mode_e;

    localparam int unsigned DEF_HBP   = 144;
    localparam int unsigned DEF_VBP   = 31;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

endpackage

// File: rtl/vga_frame_ctl.sv
// Frame-boundary control: detects the rising edge of (hc,vc)==(0,0) and, on that
// tick, latches the requested mode and advances the scroll offset.
module vga_frame_ctl
    import vga_pattern_gen_pkg::*;
#(
    parameter int unsigned SCROLL_STEP = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic [2:0] mode_sel,
    input  logic       scroll_en,
    output logic [2:0] cur_mode,
    output logic [9:0] offset,
    output logic       frame_tick
);

    logic at_origin;
    logic at_origin_q;
    logic tick;

    assign at_origin = (hc == 10'd0) && (vc == 10'd0);
    // Edge detect so counters parked at the origin yield a single tick.
    assign tick      = at_origin && !at_origin_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            at_origin_q <= 1'b0;
            cur_mode    <= ModeBlack;
            offset      <= '0;
            frame_tick  <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            frame_tick  <= tick;
            if (tick) begin
                cur_mode <= mode_sel;
                if (scroll_en) begin
                    offset <= offset + 10'(SCROLL_STEP);
                end
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Selectable test-pattern colour generator for the 640x480 VGA path; colour is
// registered and lags hc/vc by one clock.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int unsigned RW          = 3,
    parameter int unsigned GW          = 3,
    parameter int unsigned BW          = 2,
    parameter int unsigned HBP         = DEF_HBP,
    parameter int unsigned VBP         = DEF_VBP,
    parameter int unsigned STRIPE_LOG2 = 4,
    parameter int unsigned SCROLL_STEP = 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          vidon,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    input  logic [2:0]    mode_sel,
    input  logic          scroll_en,
    output logic [RW-1:0] red,
    output logic [GW-1:0] green,
    output logic [BW-1:0] blue,
    output logic          frame_tick,
    output logic [2:0]    cur_mode
);

    logic [9:0]    offset;
    logic [9:0]    x, y, xs, ys;
    logic [2:0]    bar_idx;
    logic          b;
    logic [RW-1:0] red_d;
    logic [GW-1:0] green_d;
    logic [BW-1:0] blue_d;
    logic          unused_bits;

    vga_frame_ctl #(
        .SCROLL_STEP (SCROLL_STEP)
    ) u_frame_ctl (
        .clk        (clk),
        .clr_n      (clr_n),
        .hc         (hc),
        .vc         (vc),
        .mode_sel   (mode_sel),
        .scroll_en  (scroll_en),
        .cur_mode   (cur_mode),
        .offset     (offset),
        .frame_tick (frame_tick)
    );

    assign x       = hc - 10'(HBP);
    assign y       = vc - 10'(VBP);
    assign xs      = x + offset;
    assign ys      = y + offset;
    assign bar_idx = xs[9:7];

    assign unused_bits = ^{xs, ys};

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        b       = 1'b0;
        if (vidon) begin
            case (cur_mode)
                ModeHStripe: begin
                    b       = ys[STRIPE_LOG2];
                    red_d   = {RW{b}};
                    green_d = {GW{~b}};
                end
                ModeVStripe: begin
                    b      = xs[STRIPE_LOG2];
                    red_d  = {RW{b}};
                    blue_d = {BW{~b}};
                end
                ModeChecker: begin
                    // Only x scrolls, so the checkerboard slides sideways.
                    b       = xs[STRIPE_LOG2] ^ y[STRIPE_LOG2];
                    red_d   = {RW{b}};
                    green_d = {GW{b}};
                    blue_d  = {BW{b}};
                end
                ModeBars: begin
                    red_d   = {RW{bar_idx[2]}};
                    green_d = {GW{bar_idx[1]}};
                    blue_d  = {BW{bar_idx[0]}};
                end
                ModeRamp: begin
                    red_d   = x[9 -: RW];
                    green_d = y[8 -: GW];
                    blue_d  = offset[9 -: BW];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= red_d;
            green <= green_d;
            blue  <= blue_d;
        end
    end

endmodule
